ahb_afifo_issue: RTL and testbench
==================================

Name: ahb_afifo_issue

Overview:
- Read-side consumer of the 35-bit, 2-deep asynchronous command FIFO in the AHB 1x6 sub-matrix, running in that FIFO's read-clock domain.
- Pops header and write-data words from the FIFO, which is built with its fast read option: data is valid combinationally while not empty.
- Issues single AHB-Lite transfers, one outstanding at a time, on the downstream slave port.
- Pushes one 35-bit response word per transfer into the write side of the return FIFO.

Parameters:
- ADDR_B31, 1'b0, constant driven on haddr[31]; the sub-matrix window fixes this bit.
- HPROT_VAL, 4'b0011, constant hprot value.

Ports:
- clk  in  1  read-domain clock
- reset_n  in  1  synchronous, active-low reset
- fifo_rd_en  out  1  pop strobe to command FIFO
- fifo_rd_empty  in  1  command FIFO empty
- fifo_rd_data  in  35  command FIFO head word, valid when not empty
- haddr  out  32  AHB address
- htrans  out  2  IDLE=00, NONSEQ=10 only
- hwrite  out  1  AHB write
- hsize  out  3  {1'b0, header size}
- hburst  out  3  constant 3'b000 (SINGLE)
- hprot  out  4  HPROT_VAL
- hwdata  out  32  AHB write data
- hready  in  1  AHB ready
- hresp  in  2  AHB response
- hrdata  in  32  AHB read data
- rsp_wr_en  out  1  push strobe to return FIFO
- rsp_wr_full  in  1  return FIFO full
- rsp_wr_data  out  35  response word
- proto_err  out  1  sticky flag for a malformed command stream
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Command word formats:
  - Header: [34]=1, [33]=hwrite, [32:31]=hsize[1:0], [30:0]=haddr[30:0].
  - Write data: [34]=0, [33:32]=0, [31:0]=hwdata.
- Response word format: [34]=hwrite, [33:32]=hresp, [31:0]=hrdata for reads, 0 for writes.
- States: IDLE, WDATA, ADDR, DPHASE, RSP.
- IDLE:
  - If the FIFO is not empty, the head is a header, and rsp_wr_full=0: assert fifo_rd_en, latch the header.
  - Next state is ADDR for a read, WDATA for a write.
  - If the head is a data word: pop it, set proto_err, stay in IDLE.
- WDATA:
  - Data word at head: pop it, latch hwdata, go to ADDR.
  - Header at head: no pop, set proto_err, drop the pending write, go to IDLE.
  - Empty FIFO: wait; there is no timeout.
- ADDR: htrans=NONSEQ with haddr/hwrite/hsize driven for exactly one cycle; next state DPHASE.
  - The address phase is always accepted in one cycle because no transfer is outstanding.
- DPHASE:
  - htrans=IDLE; hwdata held stable.
  - Wait for hready=1, then capture hresp/hrdata and go to RSP.
  - Two-cycle ERROR: the first cycle (hready=0) is ignored; capture on the second cycle (hready=1, hresp=01).
- RSP: rsp_wr_en=1 for exactly one cycle, then IDLE.
  - Space is guaranteed: full was checked at header pop and this block is the only writer to the return FIFO.
- Latency for a read header present at cycle T:
  - pop at T;
  - NONSEQ at T+1;
  - data phase at T+2, zero-wait;
  - rsp_wr_en at T+3.
  - A write whose data word is already present adds 1 cycle.
- fifo_rd_en is asserted only while fifo_rd_empty=0, and at most once per cycle.
- Reset, synchronous, takes effect at any state including mid-transfer:
  - state returns to IDLE;
  - htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0;
  - fifo_rd_en=0, rsp_wr_en=0, rsp_wr_data=0;
  - proto_err=0, busy=0.
- hsize[1:0]=11 is passed through unchanged; this block performs no checking of it.
- proto_err clears only on reset.

Decomposition:
- Package ahb_afifo_pkg holds:
  - command and response field bit positions and widths (35-bit word constants);
  - HTRANS_IDLE/HTRANS_NONSEQ and HRESP_OKAY/HRESP_ERROR constants;
  - the state encoding.
- No sub-module: a single flat FSM with a datapath register set (~200 lines).

Test Plan:
1. Read: header {1,0,2'b10,31'h0000_1000}, hrdata=32'hDEAD_BEEF, zero wait states.
   -> NONSEQ at T+1 with haddr=32'h0000_1000 and hsize=3'b010; rsp_wr_data=35'h0_DEAD_BEEF with rsp_wr_en at T+3.
2. Write: header {1,1,2'b00,31'h20}, then data word 32'h0000_00A5; slave inserts 2 wait states.
   -> hwrite=1, hsize=0, hwdata=32'hA5 held through the wait states; one response with [34]=1, hresp=0, data 0.
3. Slave ERROR on a read (cycle 1 hready=0/hresp=01, cycle 2 hready=1/hresp=01).
   -> exactly one rsp_wr_en; rsp_wr_data[33:32]=01; no NONSEQ issued during the ERROR cycles.
4. rsp_wr_full=1 with a header present.
   -> no pop, htrans stays IDLE; after full deasserts, the transfer proceeds and a single response is pushed.
5. Protocol errors.
   - A data word with FIFO otherwise idle -> popped, proto_err=1, no AHB activity.
   - Write header followed by a read header -> read header not popped during WDATA, proto_err=1, then the read completes normally.
6. reset_n low for 1 cycle during DPHASE.
   -> the next cycle shows all outputs at their reset values; no response pushed; the next header is processed normally.

Source files
------------

// File: rtl/ahb_afifo_pkg.sv
// Shared definitions for the AHB command-FIFO issue engine:
// command/response word layout, AHB encodings and FSM states.
package ahb_afifo_pkg;

    localparam int CMD_W        = 35;
    localparam int DATA_W       = 32;
    localparam int CMD_HDR_BIT  = 34;
    localparam int CMD_WR_BIT   = 33;
    localparam int CMD_SIZE_LSB = 31;
    localparam int CMD_SIZE_W   = 2;
    localparam int CMD_ADDR_W   = 31;
    localparam int RSP_WR_BIT   = 34;
    localparam int RSP_RESP_LSB = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_ADDR,
        ST_DPHASE,
        ST_RSP
    } state_e;

endpackage

// File: rtl/ahb_afifo_issue.sv
// Drains the command FIFO and issues single AHB-Lite transfers,
// one outstanding, pushing one response word per transfer.
module ahb_afifo_issue
    import ahb_afifo_pkg::*;
#(
    parameter logic       ADDR_B31  = 1'b0,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              fifo_rd_en,
    input  logic              fifo_rd_empty,
    input  logic [CMD_W-1:0]  fifo_rd_data,
    output logic [31:0]       haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [31:0]       hwdata,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [31:0]       hrdata,
    output logic              rsp_wr_en,
    input  logic              rsp_wr_full,
    output logic [CMD_W-1:0]  rsp_wr_data,
    output logic              proto_err,
    output logic              busy
);

    state_e                  state_q, state_d;
    logic [CMD_ADDR_W-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [CMD_SIZE_W-1:0]   size_q, size_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [CMD_W-1:0]        rsp_q, rsp_d;
    logic                    perr_q, perr_d;
    logic                    is_hdr;

    assign is_hdr = fifo_rd_data[CMD_HDR_BIT];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        rsp_d      = rsp_q;
        perr_d     = perr_q;
        fifo_rd_en = 1'b0;
        rsp_wr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_rd_empty) begin
                    if (!is_hdr) begin
                        fifo_rd_en = 1'b1;
                        perr_d     = 1'b1;
                    end else if (!rsp_wr_full) begin
                        fifo_rd_en = 1'b1;
                        addr_d     = fifo_rd_data[CMD_ADDR_W-1:0];
                        wr_d       = fifo_rd_data[CMD_WR_BIT];
                        size_d     = fifo_rd_data[CMD_SIZE_LSB +: CMD_SIZE_W];
                        state_d    = fifo_rd_data[CMD_WR_BIT] ? ST_WDATA
                                                              : ST_ADDR;
                    end
                end
            end
            ST_WDATA: begin
                if (!fifo_rd_empty) begin
                    if (!is_hdr) begin
                        fifo_rd_en = 1'b1;
                        wdata_d    = fifo_rd_data[DATA_W-1:0];
                        state_d    = ST_ADDR;
                    end else begin
                        // leave the header queued for the next IDLE pass
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADDR: state_d = ST_DPHASE;
            ST_DPHASE: begin
                if (hready) begin
                    rsp_d   = {wr_q, hresp,
                               wr_q ? {DATA_W{1'b0}} : hrdata};
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_wr_en = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // no side effects on either FIFO while reset is held
        if (!reset_n) begin
            fifo_rd_en = 1'b0;
            rsp_wr_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            perr_q  <= perr_d;
        end
    end

    assign htrans      = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr       = {ADDR_B31, addr_q};
    assign hwrite      = wr_q;
    assign hsize       = {1'b0, size_q};
    assign hburst      = 3'b000;
    assign hprot       = HPROT_VAL;
    assign hwdata      = wdata_q;
    assign rsp_wr_data = rsp_q;
    assign proto_err   = perr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_afifo_issue.sv
// Scoreboard bench for ahb_afifo_issue: FIFO model, AHB slave model,
// expected address phases and responses queued at stimulus time.
module tb_ahb_afifo_issue;
    import ahb_afifo_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        fifo_rd_en;
    logic        fifo_rd_empty;
    logic [34:0] fifo_rd_data;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        rsp_wr_en;
    logic        rsp_wr_full;
    logic [34:0] rsp_wr_data;
    logic        proto_err;
    logic        busy;

    ahb_afifo_issue dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data (fifo_rd_data),
        .haddr        (haddr),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .hsize        (hsize),
        .hburst       (hburst),
        .hprot        (hprot),
        .hwdata       (hwdata),
        .hready       (hready),
        .hresp        (hresp),
        .hrdata       (hrdata),
        .rsp_wr_en    (rsp_wr_en),
        .rsp_wr_full  (rsp_wr_full),
        .rsp_wr_data  (rsp_wr_data),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_pass;
    int cyc, pop_cnt, ns_cnt, rsp_cnt;
    int hdr_pop_cyc, ns_cyc, rsp_cyc;
    int dp_left, ws;
    bit slv_err, chk_wd, dp_drv, pend;
    logic [31:0] rd_val, exp_wd;
    logic [34:0] fq[$];
    logic [34:0] exp_rsp[$];
    logic [35:0] exp_addr[$];
    logic [34:0] tmp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [34:0] hdr(logic w, logic [1:0] sz,
                                        logic [30:0] a);
        return {1'b1, w, sz, a};
    endfunction

    task automatic push_cmd(input logic [34:0] w);
        fq.push_back(w);
        fifo_rd_empty = 1'b0;
        fifo_rd_data  = fq[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (exp_rsp.size() == 0 && fq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({"done_", tag}, done, 1);
    endtask

    // Monitor/models: sample at negedge, drive at posedge+1
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            pend = fifo_rd_en;
            if (fifo_rd_en) begin
                pop_cnt++;
                chk("pop_nonempty", fifo_rd_empty, 0);
                if (fifo_rd_data[34]) hdr_pop_cyc = cyc;
            end
            if (htrans == HTRANS_NONSEQ) begin
                ns_cnt++;
                ns_cyc = cyc;
                chk("addr_pending", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0)
                    chk("addr_phase", {hwrite, hsize, haddr},
                        exp_addr.pop_front());
                dp_left = slv_err ? 2 : ws + 1;
            end
            if (dp_drv && chk_wd) begin
                chk("hwdata_hold", hwdata, exp_wd);
                chk("dp_htrans", htrans, HTRANS_IDLE);
            end
            if (rsp_wr_en) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                chk("rsp_pending", exp_rsp.size() != 0, 1);
                if (exp_rsp.size() != 0)
                    chk("rsp_word", rsp_wr_data, exp_rsp.pop_front());
            end
            @(posedge clk);
            #1;
            if (pend && fq.size() != 0) tmp = fq.pop_front();
            fifo_rd_empty = (fq.size() == 0);
            fifo_rd_data  = (fq.size() != 0) ? fq[0] : 35'h0;
            dp_drv = 1'b0;
            if (dp_left > 0) begin
                dp_drv = 1'b1;
                hready = (dp_left == 1);
                hresp  = slv_err ? HRESP_ERROR : HRESP_OKAY;
                hrdata = rd_val;
                dp_left--;
            end else begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
                hrdata = 32'h0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_ns, b_rsp, b_pop;
        bit seen;
        reset_n = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data = '0;
        hready = 1'b1;
        hresp = HRESP_OKAY;
        hrdata = '0;
        rsp_wr_full = 1'b0;
        ws = 0; slv_err = 0; rd_val = '0; chk_wd = 0; dp_left = 0;
        exp_wd = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_htrans", htrans, HTRANS_IDLE);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_wr_en", rsp_wr_en, 0);
        chk("rst_rsp", rsp_wr_data, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_busy", busy, 0);
        chk("hburst", hburst, 3'b000);
        chk("hprot", hprot, 4'b0011);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: zero-wait read
        rd_val = 32'hDEAD_BEEF;
        exp_addr.push_back({1'b0, 3'b010, 32'h0000_1000});
        exp_rsp.push_back(35'h0_DEAD_BEEF);
        b_rsp = rsp_cnt;
        push_cmd(hdr(1'b0, 2'b10, 31'h1000));
        wait_done("rd");
        chk("rd_ns_lat", ns_cyc - hdr_pop_cyc, 1);
        chk("rd_rsp_lat", rsp_cyc - hdr_pop_cyc, 3);
        chk("rd_rsp_cnt", rsp_cnt - b_rsp, 1);

        // 2: write with two wait states
        ws = 2; chk_wd = 1; exp_wd = 32'h0000_00A5;
        exp_addr.push_back({1'b1, 3'b000, 32'h0000_0020});
        exp_rsp.push_back({1'b1, 2'b00, 32'h0});
        push_cmd(hdr(1'b1, 2'b00, 31'h20));
        push_cmd(35'h0_0000_00A5);
        wait_done("wr");
        chk("wr_ns_lat", ns_cyc - hdr_pop_cyc, 2);
        chk("wr_rsp_lat", rsp_cyc - hdr_pop_cyc, 6);
        chk_wd = 0; ws = 0;

        // 3: two-cycle ERROR response
        slv_err = 1; rd_val = 32'h1234_5678;
        exp_addr.push_back({1'b0, 3'b010, 32'h0000_0040});
        exp_rsp.push_back({1'b0, 2'b01, 32'h1234_5678});
        b_ns = ns_cnt; b_rsp = rsp_cnt;
        push_cmd(hdr(1'b0, 2'b10, 31'h40));
        wait_done("err");
        chk("err_ns_cnt", ns_cnt - b_ns, 1);
        chk("err_rsp_cnt", rsp_cnt - b_rsp, 1);
        slv_err = 0;

        // 4: return FIFO full holds off the pop
        rsp_wr_full = 1'b1; rd_val = 32'hCAFE_0001;
        exp_addr.push_back({1'b0, 3'b001, 32'h0000_0300});
        exp_rsp.push_back({1'b0, 2'b00, 32'hCAFE_0001});
        b_ns = ns_cnt; b_rsp = rsp_cnt; b_pop = pop_cnt;
        push_cmd(hdr(1'b0, 2'b01, 31'h300));
        repeat (5) tick();
        chk("full_pop", pop_cnt - b_pop, 0);
        chk("full_ns", ns_cnt - b_ns, 0);
        chk("full_htrans", htrans, HTRANS_IDLE);
        chk("full_busy", busy, 0);
        rsp_wr_full = 1'b0;
        wait_done("full");
        chk("full_rsp_cnt", rsp_cnt - b_rsp, 1);

        // 5a: stray data word
        b_ns = ns_cnt; b_rsp = rsp_cnt;
        push_cmd(35'h0_0000_0055);
        repeat (3) tick();
        chk("stray_perr", proto_err, 1);
        chk("stray_popped", fq.size(), 0);
        chk("stray_ns", ns_cnt - b_ns, 0);
        chk("stray_rsp", rsp_cnt - b_rsp, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("perr_clr", proto_err, 0);

        // 5b: write header followed by a read header
        rd_val = 32'h0BAD_F00D;
        exp_addr.push_back({1'b0, 3'b010, 32'h0000_0500});
        exp_rsp.push_back({1'b0, 2'b00, 32'h0BAD_F00D});
        b_ns = ns_cnt; b_rsp = rsp_cnt; b_pop = pop_cnt;
        push_cmd(hdr(1'b1, 2'b00, 31'h400));
        push_cmd(hdr(1'b0, 2'b10, 31'h500));
        wait_done("hdrhdr");
        chk("hh_perr", proto_err, 1);
        chk("hh_pops", pop_cnt - b_pop, 2);
        chk("hh_ns", ns_cnt - b_ns, 1);
        chk("hh_rsp", rsp_cnt - b_rsp, 1);

        // 6: reset in the data phase
        ws = 3; rd_val = 32'h5555_AAAA;
        exp_addr.push_back({1'b0, 3'b010, 32'h0000_0600});
        exp_rsp.push_back({1'b0, 2'b00, 32'h5555_AAAA});
        b_ns = ns_cnt;
        push_cmd(hdr(1'b0, 2'b10, 31'h600));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ns_cnt > b_ns) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst6_ns_seen", seen, 1);
        chk("rst6_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_rsp.delete();
        dp_left = 0;
        ws = 0;
        @(negedge clk);
        chk("r6_htrans", htrans, HTRANS_IDLE);
        chk("r6_haddr", haddr, 0);
        chk("r6_hwrite", hwrite, 0);
        chk("r6_hsize", hsize, 0);
        chk("r6_hwdata", hwdata, 0);
        chk("r6_rd_en", fifo_rd_en, 0);
        chk("r6_wr_en", rsp_wr_en, 0);
        chk("r6_rsp", rsp_wr_data, 0);
        chk("r6_perr", proto_err, 0);
        chk("r6_busy", busy, 0);
        b_rsp = rsp_cnt;
        repeat (4) tick();
        chk("r6_no_rsp", rsp_cnt - b_rsp, 0);
        rd_val = 32'h0F0F_0F0F;
        exp_addr.push_back({1'b0, 3'b010, 32'h0000_0700});
        exp_rsp.push_back({1'b0, 2'b00, 32'h0F0F_0F0F});
        push_cmd(hdr(1'b0, 2'b10, 31'h700));
        wait_done("after_rst");
        chk("r6_next_rsp", rsp_cnt - b_rsp, 1);

        // 7: hsize 11 and top address bits pass through
        rd_val = 32'h8765_4321;
        exp_addr.push_back({1'b0, 3'b011, 32'h7FFF_FFFC});
        exp_rsp.push_back({1'b0, 2'b00, 32'h8765_4321});
        push_cmd(hdr(1'b0, 2'b11, 31'h7FFF_FFFC));
        wait_done("size3");

        chk("sb_empty", exp_rsp.size() + exp_addr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
